instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 183 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Encodes MIPS-style instruction requests into 32-bit words and writes them
// to a 256-word instruction memory; `ENC_CHECKSUM_EN adds an XOR checksum.
// Ports:
//   clk, rst_n (sync, active-low)
//   in_valid/in_ready handshake
//   in_kind, in_aluctr, in_rs/rt/rd, in_imm, in_target, in_last
//   mem_we, mem_addr, mem_wdata: memory write port
//   done, err: one-cycle pulses
//   full: address 255 has been written
//   checksum: running XOR of written words (0 without the macro)
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [2:0]  in_aluctr,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        done,
  output logic        err,
  output logic        full,
  output logic [31:0] checksum
);

  typedef enum logic [2:0] {
    IDLE, ENCODE, WRITE, DONE, HALT
  } state_t;

  state_t state, state_n;

  logic [2:0]  kind, aluctr;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic        last;
  logic [7:0]  ptr;
  logic        full_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;

  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic        bad_alu, bad;
  logic [31:0] word;
  logic        xfer;

  assign in_ready = rst_n && (state == IDLE) && !full_q;
  assign xfer     = in_valid && in_ready;
  assign mem_we   = (state == WRITE);
  assign done     = (state == DONE);
  assign err      = (state == ENCODE) && bad;
  assign full     = full_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    funct   = 6'h00;
    shamt   = 5'd0;
    bad_alu = 1'b0;
    case (aluctr)
      3'd0: funct = 6'h20;
      3'd1: funct = 6'h22;
      3'd2: funct = 6'h24;
      3'd3: funct = 6'h25;
      3'd4: funct = 6'h26;
      3'd5: begin
        funct = 6'h00;
        shamt = imm[4:0];
      end
      3'd6: begin
        funct = 6'h02;
        shamt = imm[4:0];
      end
      default: bad_alu = 1'b1;
    endcase
  end

  always_comb begin
    word = 32'd0;
    bad  = 1'b0;
    case (kind)
      3'd0: begin
        word = {6'h00, rs, rt, rd, shamt, funct};
        bad  = bad_alu;
      end
      3'd1: word = {6'h0d, rs, rt, imm};
      3'd2: word = {6'h23, rs, rt, imm};
      3'd3: word = {6'h2b, rs, rt, imm};
      3'd4: word = {6'h04, rs, rt, imm};
      3'd5: word = {6'h02, target};
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (xfer) state_n = ENCODE;
      ENCODE: state_n = bad ? IDLE : WRITE;
      WRITE: begin
        if (last)
          state_n = DONE;
        else if (ptr == 8'hff)
          state_n = HALT;
        else
          state_n = IDLE;
      end
      DONE:   state_n = IDLE;
      HALT:   state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      kind    <= 3'd0;
      aluctr  <= 3'd0;
      rs      <= 5'd0;
      rt      <= 5'd0;
      rd      <= 5'd0;
      imm     <= 16'd0;
      target  <= 26'd0;
      last    <= 1'b0;
      ptr     <= 8'd0;
      full_q  <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 32'd0;
    end else begin
      state <= state_n;
      if (xfer) begin
        kind   <= in_kind;
        aluctr <= in_aluctr;
        rs     <= in_rs;
        rt     <= in_rt;
        rd     <= in_rd;
        imm    <= in_imm;
        target <= in_target;
        last   <= in_last;
      end
      // Output port registers only change when a legal word is staged.
      if (state == ENCODE && !bad) begin
        addr_q  <= ptr;
        wdata_q <= word;
      end
      // Pointer saturates at 255; full marks that the last slot is used.
      if (state == WRITE) begin
        if (ptr == 8'hff)
          full_q <= 1'b1;
        else
          ptr <= ptr + 8'd1;
      end
      if (state == DONE) begin
        ptr    <= 8'd0;
        full_q <= 1'b0;
      end
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [31:0] cks;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cks <= 32'd0;
    else if (state == WRITE)
      cks <= cks ^ wdata_q;
  end

  assign checksum = cks;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
// Build with +define+ENC_CHECKSUM_EN to check the checksum accumulator.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_kind = '0;
  logic [2:0]  in_aluctr = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        in_last = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        done;
  logic        err;
  logic        full;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;
  logic [31:0] acc;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_kind(in_kind),
    .in_aluctr(in_aluctr),
    .in_rs(in_rs),
    .in_rt(in_rt),
    .in_rd(in_rd),
    .in_imm(in_imm),
    .in_target(in_target),
    .in_last(in_last),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .done(done),
    .err(err),
    .full(full),
    .checksum(checksum)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outs();
    check("rst_in_ready", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_full", full, 0);
    check("rst_cks", checksum, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", in_ready, 1);
    acc = 32'd0;
  endtask

  // Returns at posedge+1 of the transfer, i.e. inside ENCODE.
  task automatic send(input [2:0] k, input [2:0] a,
                      input [4:0] s, input [4:0] t, input [4:0] d,
                      input [15:0] im, input [25:0] tg, input lst);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", in_ready, 1);
    in_kind = k;
    in_aluctr = a;
    in_rs = s;
    in_rt = t;
    in_rd = d;
    in_imm = im;
    in_target = tg;
    in_last = lst;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_kind = 3'd6;
    in_aluctr = 3'd7;
    in_rs = 5'h1f;
    in_rt = 5'h1f;
    in_rd = 5'h1f;
    in_imm = 16'ha5a5;
    in_target = 26'h3ffffff;
    in_last = 1'b0;
  endtask

  task automatic expect_write(input logic [7:0] addr,
                              input logic [31:0] w);
    @(negedge clk);
    check("enc_no_we", mem_we, 0);
    check("enc_no_err", err, 0);
    @(negedge clk);
    check("wr_we", mem_we, 1);
    check("wr_addr", mem_addr, addr);
    check("wr_data", mem_wdata, w);
    acc = acc ^ w;
  endtask

  task automatic expect_err();
    @(negedge clk);
    check("err_pulse", err, 1);
    check("err_no_we", mem_we, 0);
    @(negedge clk);
    check("err_gone", err, 0);
    check("err_no_we2", mem_we, 0);
    check("err_idle", in_ready, 1);
  endtask

  task automatic check_cks();
`ifdef ENC_CHECKSUM_EN
    check("checksum", checksum, acc);
`else
    check("checksum_off", checksum, 0);
`endif
  endtask

  initial begin
    acc = 32'd0;
    do_reset();

    // Basic R-type add
    send(3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0, 1'b0);
    expect_write(8'd0, 32'h00221820);
    @(negedge clk);
    check("idle_after_wr", in_ready, 1);
    check("we_drop", mem_we, 0);
    check("hold_data", mem_wdata, 32'h00221820);
    check_cks();

    // lw, ori, j(last), then pointer back at 0
    do_reset();
    send(3'd2, 3'd0, 5'd4, 5'd5, 5'd0, 16'h0008, 26'd0, 1'b0);
    expect_write(8'd0, 32'h8C850008);
    send(3'd1, 3'd0, 5'd0, 5'd2, 5'd0, 16'hFFFF, 26'd0, 1'b0);
    expect_write(8'd1, 32'h3402FFFF);
    send(3'd5, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0000010, 1'b1);
    expect_write(8'd2, 32'h08000010);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_no_ready", in_ready, 0);
    @(negedge clk);
    check("done_gone", done, 0);
    check("ready_post_done", in_ready, 1);
    check_cks();

    // shamt only on shifts; sw and beq encodings
    send(3'd0, 3'd2, 5'd1, 5'd2, 5'd3, 16'h001F, 26'd0, 1'b0);
    expect_write(8'd0, 32'h00221824);
    send(3'd0, 3'd5, 5'd0, 5'd2, 5'd3, 16'h0004, 26'd0, 1'b0);
    expect_write(8'd1, 32'h00021900);
    send(3'd3, 3'd0, 5'd29, 5'd31, 5'd0, 16'h0004, 26'd0, 1'b0);
    expect_write(8'd2, 32'hAFBF0004);
    send(3'd4, 3'd0, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'd0, 1'b0);
    expect_write(8'd3, 32'h1022FFFE);

    // Illegal kind and illegal ALU code
    send(3'd6, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0, 1'b0);
    expect_err();
    send(3'd0, 3'd7, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0, 1'b0);
    expect_err();
    check("err_hold_data", mem_wdata, 32'h1022FFFE);
    send(3'd0, 3'd1, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0, 1'b0);
    expect_write(8'd4, 32'h00221822);
    check_cks();

    // Fill all 256 slots, then HALT
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      send(3'd2, 3'd0, b[4:0], ~b[4:0], 5'd0, {b, ~b}, 26'd0, 1'b0);
      expect_write(b, {6'h23, b[4:0], ~b[4:0], b, ~b});
    end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halt_full", full, 1);
      check("halt_ready", in_ready, 0);
      check("halt_no_we", mem_we, 0);
    end
    in_valid = 1'b0;
    check_cks();

    // Last instruction landing on address 255: DONE beats HALT
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      send(3'd1, 3'd0, 5'd0, b[4:0], 5'd0, {8'd0, b}, 26'd0, i == 255);
      expect_write(b, {6'h0d, 5'd0, b[4:0], 8'd0, b});
    end
    @(negedge clk);
    check("p255_done", done, 1);
    @(negedge clk);
    check("p255_done_gone", done, 0);
    check("p255_full_clr", full, 0);
    check("p255_ready", in_ready, 1);
    send(3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0, 1'b0);
    expect_write(8'd0, 32'h00221820);

    // Reset dropped during WRITE
    send(3'd2, 3'd0, 5'd4, 5'd5, 5'd0, 16'h0008, 26'd0, 1'b0);
    expect_write(8'd1, 32'h8C850008);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_post_abort", in_ready, 1);
    acc = 32'd0;
    send(3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0, 1'b0);
    expect_write(8'd0, 32'h00221820);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
